// File: rtl/sram_packet_reader_if.sv
// Signal bundle between sram_packet_reader and its environment: packet request,
// jump-table / ECC-storage / SRAM read ports, output stream, page-free and ECC error.
interface sram_packet_reader_if;
    logic        rd_req;
    logic [10:0] rd_head_addr;
    logic [10:0] rd_tail_addr;
    logic [2:0]  rd_last_batch;
    logic        rd_busy;
    logic [10:0] jt_rd_addr;
    logic [15:0] jt_rd_dout;
    logic [10:0] es_rd_addr;
    logic [7:0]  es_rd_dout;
    logic        sram_rd_en;
    logic [13:0] sram_rd_addr;
    logic [15:0] sram_dout;
    logic        out_data_vld;
    logic [15:0] out_data;
    logic        out_end_of_packet;
    logic        out_ready;
    logic        page_free_vld;
    logic [10:0] page_free_addr;
    logic        ecc_err;

    modport master (
        output rd_req, rd_head_addr, rd_tail_addr, rd_last_batch,
        output jt_rd_dout, es_rd_dout, sram_dout, out_ready,
        input  rd_busy, jt_rd_addr, es_rd_addr, sram_rd_en, sram_rd_addr,
        input  out_data_vld, out_data, out_end_of_packet,
        input  page_free_vld, page_free_addr, ecc_err
    );

    modport slave (
        input  rd_req, rd_head_addr, rd_tail_addr, rd_last_batch,
        input  jt_rd_dout, es_rd_dout, sram_dout, out_ready,
        output rd_busy, jt_rd_addr, es_rd_addr, sram_rd_en, sram_rd_addr,
        output out_data_vld, out_data, out_end_of_packet,
        output page_free_vld, page_free_addr, ecc_err
    );
endinterface

// File: rtl/sram_packet_reader.sv
// Walks a linked list of SRAM pages and streams the packet out through a 2-entry FIFO.
// Optional per-page ECC check is enabled by defining SRAM_READER_ECC_CHECK_EN.
module sram_packet_reader (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_packet_reader_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] cur_page_q, tail_q, next_page_q, page_free_addr_q;
    logic [2:0]  batch_q, last_batch_q;
    logic        pg_start_q, pg_cap_q;
    logic        rtn_vld_q, rtn_last_q, page_free_vld_q;
    logic [16:0] fifo_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q;

    logic        is_tail_s, page_end_s, pop_s, issue_s, start_s;
    logic [2:0]  occ_eff_s;
    logic        ecc_err_s;
    logic [10:0] es_addr_s;
    logic        unused_s;

    // Issue decision: occupancy counts this cycle's pop so a full-rate stream never bubbles.
    always_comb begin
        is_tail_s  = (cur_page_q == tail_q);
        page_end_s = (batch_q == 3'd7) || (is_tail_s && (batch_q == last_batch_q));
        pop_s      = (count_q != 2'd0) && bus.out_ready;
        occ_eff_s  = {1'b0, count_q} - {2'b00, pop_s} + {2'b00, rtn_vld_q};
        start_s    = (state_q == IDLE) && bus.rd_req;
        issue_s    = (state_q == READ) && (occ_eff_s < 3'd2);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; the ECC compare lands on the same edge that clears rtn_vld_q,
    // so an empty pipeline in DRAIN also means the final compare is done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.rd_req) state_d = READ;
                else            state_d = IDLE;
            end
            READ: begin
                if (issue_s && page_end_s && is_tail_s) state_d = DRAIN;
                else                                     state_d = READ;
            end
            DRAIN: begin
                if ((count_q == 2'd0) && !rtn_vld_q) state_d = IDLE;
                else                                 state_d = DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and output-port mapping.
    always_comb begin
        bus.rd_busy           = (state_q != IDLE);
        bus.sram_rd_en        = issue_s;
        bus.sram_rd_addr      = issue_s ? {cur_page_q, batch_q} : 14'd0;
        bus.jt_rd_addr        = cur_page_q;
        bus.es_rd_addr        = es_addr_s;
        bus.out_data_vld      = (count_q != 2'd0);
        bus.out_data          = fifo_q[rd_ptr_q][15:0];
        bus.out_end_of_packet = (count_q != 2'd0) && fifo_q[rd_ptr_q][16];
        bus.page_free_vld     = page_free_vld_q;
        bus.page_free_addr    = page_free_addr_q;
        bus.ecc_err           = ecc_err_s;
    end

    // Page walk: batch counter, next-page pointer capture, page-free pulse, return tagging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_page_q       <= 11'd0;
            tail_q           <= 11'd0;
            next_page_q      <= 11'd0;
            last_batch_q     <= 3'd0;
            batch_q          <= 3'd0;
            pg_start_q       <= 1'b0;
            pg_cap_q         <= 1'b0;
            rtn_vld_q        <= 1'b0;
            rtn_last_q       <= 1'b0;
            page_free_vld_q  <= 1'b0;
            page_free_addr_q <= 11'd0;
        end else begin
            pg_cap_q        <= pg_start_q;
            pg_start_q      <= 1'b0;
            rtn_vld_q       <= issue_s;
            rtn_last_q      <= issue_s && page_end_s && is_tail_s;
            page_free_vld_q <= issue_s && page_end_s;
            if (issue_s && page_end_s) begin
                page_free_addr_q <= cur_page_q;
            end
            // Jump-table data for the current page is valid one cycle after the address moves.
            if (pg_cap_q) begin
                next_page_q <= bus.jt_rd_dout[10:0];
            end
            if (start_s) begin
                cur_page_q   <= bus.rd_head_addr;
                tail_q       <= bus.rd_tail_addr;
                last_batch_q <= bus.rd_last_batch;
                batch_q      <= 3'd0;
                pg_start_q   <= 1'b1;
            end else if (issue_s) begin
                batch_q <= page_end_s ? 3'd0 : batch_q + 3'd1;
                if (page_end_s && !is_tail_s) begin
                    cur_page_q <= next_page_q;
                    pg_start_q <= 1'b1;
                end
            end
        end
    end

    // Output FIFO: written by each SRAM return, read on vld && ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= 17'd0;
            fifo_q[1] <= 17'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (rtn_vld_q) begin
                fifo_q[wr_ptr_q] <= {rtn_last_q, bus.sram_dout};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, rtn_vld_q} - {1'b0, pop_s};
        end
    end

`ifdef SRAM_READER_ECC_CHECK_EN
    function automatic logic [7:0] ecc_fold(input logic [15:0] hw);
        return hw[15:8] ^ hw[7:0];
    endfunction

    logic [7:0] ecc_acc_q, es_ref_q;
    logic       ecc_err_q, ecc_pg_end_q;

    // Per-page ECC: fold returning halfwords, compare against stored value on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecc_acc_q    <= 8'd0;
            es_ref_q     <= 8'd0;
            ecc_err_q    <= 1'b0;
            ecc_pg_end_q <= 1'b0;
        end else begin
            ecc_pg_end_q <= issue_s && page_end_s;
            if (pg_cap_q) begin
                es_ref_q <= bus.es_rd_dout;
            end
            if (rtn_vld_q && ecc_pg_end_q) begin
                ecc_acc_q <= 8'd0;
                ecc_err_q <= ((ecc_acc_q ^ ecc_fold(bus.sram_dout)) != es_ref_q);
            end else begin
                if (rtn_vld_q) begin
                    ecc_acc_q <= ecc_acc_q ^ ecc_fold(bus.sram_dout);
                end
                ecc_err_q <= 1'b0;
            end
        end
    end

    assign ecc_err_s = ecc_err_q;
    assign es_addr_s = cur_page_q;
    assign unused_s  = ^bus.jt_rd_dout[15:11];
`else
    assign ecc_err_s = 1'b0;
    assign es_addr_s = 11'd0;
    assign unused_s  = ^{bus.jt_rd_dout[15:11], bus.es_rd_dout};
`endif
endmodule

// File: tb/tb_sram_packet_reader.sv
// Directed bench for sram_packet_reader: SRAM / jump-table / ECC-storage models plus
// per-scenario tasks with inline checks.
module tb_sram_packet_reader;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    sram_packet_reader_if bus ();

    sram_packet_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [10:0] jt_mem [2048];
    logic [7:0]  es_mem [2048];
    logic [3:0]  ready_pat = 4'b1001;

    // Memory content: halfword at SRAM address a is {2'b11, a}.
    function automatic logic [15:0] exp_word(input logic [10:0] p, input logic [2:0] b);
        return 16'hC000 | ({5'd0, p} << 3) | {13'd0, b};
    endfunction

    function automatic logic [7:0] page_ecc(input logic [10:0] p, input int nb);
        logic [7:0]  x;
        logic [15:0] w;
        x = 8'd0;
        for (int b = 0; b < nb; b++) begin
            w = exp_word(p, b[2:0]);
            x = x ^ w[15:8] ^ w[7:0];
        end
        return x;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Read-port models with one-cycle latency.
    always @(posedge clk) begin
        bus.jt_rd_dout <= {5'd0, jt_mem[bus.jt_rd_addr]};
        bus.es_rd_dout <= es_mem[bus.es_rd_addr];
        if (bus.sram_rd_en) bus.sram_dout <= {2'b11, bus.sram_rd_addr};
    end

    logic [15:0] got_data [$];
    logic        got_eop  [$];
    int          got_cyc  [$];
    logic [10:0] got_free [$];
    int ecc_cnt = 0, ecc_cyc = 0, es_nz = 0, req_cyc = 0, outst = 0, outst_viol = 0;

    // Monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.out_data_vld && bus.out_ready) begin
            got_data.push_back(bus.out_data);
            got_eop.push_back(bus.out_end_of_packet);
            got_cyc.push_back(cyc);
        end
        if (bus.page_free_vld) got_free.push_back(bus.page_free_addr);
        if (bus.ecc_err) begin
            ecc_cnt <= ecc_cnt + 1;
            ecc_cyc <= cyc;
        end
        if (bus.es_rd_addr != 11'd0) es_nz <= es_nz + 1;
        if (bus.rd_req && !bus.rd_busy) req_cyc <= cyc;
        if (!rst_n) begin
            outst <= 0;
        end else begin
            outst <= outst + int'(bus.sram_rd_en) - int'(bus.out_data_vld && bus.out_ready);
            if (outst + int'(bus.sram_rd_en) - int'(bus.out_data_vld && bus.out_ready) > 2)
                outst_viol <= outst_viol + 1;
        end
    end

    task automatic start_req(input logic [10:0] head, input logic [10:0] tail, input logic [2:0] lb);
        @(posedge clk); #1;
        bus.rd_head_addr  = head;
        bus.rd_tail_addr  = tail;
        bus.rd_last_batch = lb;
        bus.rd_req        = 1'b1;
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
    endtask

    task automatic wait_idle(input bit toggle, output bit done);
        done = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            bus.out_ready = toggle ? ready_pat[k % 4] : 1'b1;
            if (!bus.rd_busy) begin
                done = 1'b1;
                break;
            end
        end
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.rd_busy, bus.sram_rd_en, bus.out_data_vld, bus.out_end_of_packet,
             bus.page_free_vld, bus.ecc_err} !== 6'd0) begin
            errors++;
            $display("FAIL reset_status: got %b expected 000000", {bus.rd_busy, bus.sram_rd_en,
                     bus.out_data_vld, bus.out_end_of_packet, bus.page_free_vld, bus.ecc_err});
        end
        checks++;
        if ({bus.jt_rd_addr, bus.es_rd_addr, bus.sram_rd_addr, bus.page_free_addr, bus.out_data} !== 64'd0) begin
            errors++;
            $display("FAIL reset_addr_data: jt=%h es=%h sram=%h free=%h data=%h expected all 0",
                     bus.jt_rd_addr, bus.es_rd_addr, bus.sram_rd_addr, bus.page_free_addr, bus.out_data);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_page();
        int  db, fb;
        bit  done;
        db = got_data.size();
        fb = got_free.size();
        es_mem[5] = page_ecc(11'd5, 4);
        start_req(11'd5, 11'd5, 3'd3);
        wait_idle(1'b0, done);
        checks++;
        if (!done) begin errors++; $display("FAIL single_timeout: rd_busy still 1 after 400 cycles"); end
        checks++;
        if (got_data.size() - db !== 4) begin
            errors++; $display("FAIL single_count: got %0d expected 4", got_data.size() - db);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({got_eop[db+i], got_data[db+i]} !== {(i == 3), exp_word(11'd5, i[2:0])}) begin
                    errors++;
                    $display("FAIL single_word%0d: got eop=%b data=%h expected eop=%b data=%h", i,
                             got_eop[db+i], got_data[db+i], (i == 3), exp_word(11'd5, i[2:0]));
                end
            end
            checks++;
            if (got_cyc[db] - req_cyc !== 3) begin
                errors++; $display("FAIL single_latency: got %0d expected 3", got_cyc[db] - req_cyc);
            end
        end
        checks++;
        if ((got_free.size() - fb !== 1) || (got_free[got_free.size()-1] !== 11'd5)) begin
            errors++; $display("FAIL single_free: got %0d pulses last=%0d expected 1 pulse page 5",
                               got_free.size() - fb, got_free[got_free.size()-1]);
        end
    endtask

    // Three-page packet 10->20->30, last_batch 7; shared by the ready, backpressure and ECC tests.
    task automatic run_three(input string name, input bit toggle, input bit extra_req, input int ecc_exp);
        int  db, fb, eb, vb, nb;
        bit  done;
        logic [10:0] pages [3];
        pages = '{11'd10, 11'd20, 11'd30};
        db = got_data.size(); fb = got_free.size(); eb = ecc_cnt; vb = outst_viol; nb = es_nz;
        start_req(11'd10, 11'd30, 3'd7);
        if (extra_req) begin
            repeat (3) @(posedge clk);
            #1;
            bus.rd_head_addr = 11'd5; bus.rd_tail_addr = 11'd5; bus.rd_last_batch = 3'd0;
            bus.rd_req = 1'b1;
            @(posedge clk); #1;
            bus.rd_req = 1'b0;
        end
        wait_idle(toggle, done);
        checks++;
        if (!done) begin errors++; $display("FAIL %s_timeout: rd_busy still 1", name); end
        checks++;
        if (got_data.size() - db !== 24) begin
            errors++; $display("FAIL %s_count: got %0d expected 24", name, got_data.size() - db);
        end else begin
            for (int i = 0; i < 24; i++) begin
                checks++;
                if ({got_eop[db+i], got_data[db+i]} !== {(i == 23), exp_word(pages[i/8], i[2:0])}) begin
                    errors++;
                    $display("FAIL %s_word%0d: got eop=%b data=%h expected eop=%b data=%h", name, i,
                             got_eop[db+i], got_data[db+i], (i == 23), exp_word(pages[i/8], i[2:0]));
                end
            end
            if (!toggle) begin
                checks++;
                if (got_cyc[db+23] - got_cyc[db] !== 23) begin
                    errors++; $display("FAIL %s_throughput: span %0d expected 23", name, got_cyc[db+23] - got_cyc[db]);
                end
            end
`ifdef SRAM_READER_ECC_CHECK_EN
            if (ecc_exp != 0) begin
                checks++;
                if (ecc_cyc !== got_cyc[db+15]) begin
                    errors++; $display("FAIL %s_ecc_time: got cycle %0d expected %0d", name, ecc_cyc, got_cyc[db+15]);
                end
            end
`endif
        end
        checks++;
        if ((got_free.size() - fb !== 3) || (got_free[fb] !== 11'd10) || (got_free[fb+1] !== 11'd20)
            || (got_free[fb+2] !== 11'd30)) begin
            errors++; $display("FAIL %s_free: got %0d pulses, expected pages 10,20,30 in order", name, got_free.size() - fb);
        end
        checks++;
        if ((bus.rd_busy !== 1'b0) || (bus.out_data_vld !== 1'b0)) begin
            errors++; $display("FAIL %s_idle: got busy=%b vld=%b expected 0 0", name, bus.rd_busy, bus.out_data_vld);
        end
        checks++;
        if (outst_viol - vb !== 0) begin
            errors++; $display("FAIL %s_outstanding: got %0d cycles over 2 expected 0", name, outst_viol - vb);
        end
        checks++;
        if (ecc_cnt - eb !== ecc_exp) begin
            errors++; $display("FAIL %s_ecc_count: got %0d expected %0d", name, ecc_cnt - eb, ecc_exp);
        end
`ifndef SRAM_READER_ECC_CHECK_EN
        checks++;
        if (es_nz - nb !== 0) begin
            errors++; $display("FAIL %s_es_addr: got %0d nonzero cycles expected 0", name, es_nz - nb);
        end
`endif
    endtask

    task automatic test_three_pages();
        run_three("three", 1'b0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        run_three("bp", 1'b1, 1'b0, 0);
    endtask

    task automatic test_busy_ignore();
        run_three("busy", 1'b0, 1'b1, 0);
    endtask

    task automatic test_ecc();
`ifdef SRAM_READER_ECC_CHECK_EN
        es_mem[20] = es_mem[20] ^ 8'h01;
        run_three("ecc", 1'b0, 1'b0, 1);
        es_mem[20] = es_mem[20] ^ 8'h01;
`else
        run_three("ecc_off", 1'b0, 1'b0, 0);
`endif
    endtask

    task automatic test_reset_mid();
        int  db, fb;
        bit  done, hit;
        db = got_data.size();
        hit = 1'b0;
        start_req(11'd10, 11'd30, 3'd7);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (got_data.size() - db >= 5) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rstmid_reach5: got %0d words expected 5", got_data.size() - db); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.rd_busy, bus.sram_rd_en, bus.out_data_vld, bus.out_end_of_packet, bus.page_free_vld,
             bus.ecc_err, bus.out_data, bus.sram_rd_addr, bus.jt_rd_addr} !== 47'd0) begin
            errors++;
            $display("FAIL rstmid_async: busy=%b en=%b vld=%b eop=%b free=%b data=%h sram=%h jt=%h expected all 0",
                     bus.rd_busy, bus.sram_rd_en, bus.out_data_vld, bus.out_end_of_packet,
                     bus.page_free_vld, bus.out_data, bus.sram_rd_addr, bus.jt_rd_addr);
        end
        fb = got_free.size();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_free.size() !== fb) begin
            errors++; $display("FAIL rstmid_no_free: got %0d pulses expected 0", got_free.size() - fb);
        end
        db = got_data.size();
        start_req(11'd7, 11'd7, 3'd2);
        wait_idle(1'b0, done);
        checks++;
        if (!done || (got_data.size() - db !== 3)) begin
            errors++; $display("FAIL rstmid_fresh_count: got %0d words done=%b expected 3", got_data.size() - db, done);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({got_eop[db+i], got_data[db+i]} !== {(i == 2), exp_word(11'd7, i[2:0])}) begin
                    errors++; $display("FAIL rstmid_word%0d: got eop=%b data=%h expected eop=%b data=%h", i,
                                       got_eop[db+i], got_data[db+i], (i == 2), exp_word(11'd7, i[2:0]));
                end
            end
        end
        checks++;
        if ((got_free.size() - fb !== 1) || (got_free[got_free.size()-1] !== 11'd7)) begin
            errors++; $display("FAIL rstmid_free: got %0d pulses expected 1 pulse page 7", got_free.size() - fb);
        end
    endtask

    initial begin
        bus.rd_req = 1'b0;
        bus.rd_head_addr = 11'd0;
        bus.rd_tail_addr = 11'd0;
        bus.rd_last_batch = 3'd0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            jt_mem[i] = 11'd99;
            es_mem[i] = 8'd0;
        end
        jt_mem[10] = 11'd20;
        jt_mem[20] = 11'd30;
        es_mem[10] = page_ecc(11'd10, 8);
        es_mem[20] = page_ecc(11'd20, 8);
        es_mem[30] = page_ecc(11'd30, 8);
        es_mem[7]  = page_ecc(11'd7, 3);
        test_reset();
        test_single_page();
        test_three_pages();
        test_backpressure();
        test_busy_ignore();
        test_ecc();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
